// File: rtl/alu_multicycle.sv
// Clocked ALU with a valid/ready handshake. Single-cycle ops finish in one step.
// Shifts and multiply iterate one bit per cycle through a shared IDLE/EXEC/DONE FSM.
module alu_multicycle #(
    parameter int WIDTH = 8,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       control,
    input  logic [WIDTH-1:0] regInSAR,
    input  logic [WIDTH-1:0] regIn,
    output logic [WIDTH-1:0] regOut,
    output logic             branch,
    output logic             zero,
    output logic             carry,
    output logic             out_valid
);

    localparam int CW = SHW + 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    typedef enum logic [2:0] {
        OP_ADD, OP_NAND, OP_BZ, OP_SLT, OP_SUB, OP_SHL, OP_SHR, OP_MUL
    } op_t;

    state_t             r_state, w_next;
    op_t                r_op;
    op_t                w_op;
    logic [WIDTH-1:0]   r_a, r_sh;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_res;
    logic               r_branch, r_zero, r_carry;

    logic [SHW-1:0]     w_shamt;
    logic [WIDTH:0]     w_sum, w_diff, w_mul_sum;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   w_res, w_exec_res;
    logic               w_carry, w_branch, w_exec_carry, w_multi, w_last;

    assign w_op      = op_t'(control);
    assign w_shamt   = regIn[SHW-1:0];
    assign w_sum     = {1'b0, regInSAR} + {1'b0, regIn};
    assign w_diff    = {1'b0, regInSAR} - {1'b0, regIn};
    assign w_multi   = (w_op == OP_MUL) ||
                       ((w_op == OP_SHL || w_op == OP_SHR) && (w_shamt != '0));
    assign w_last    = (r_cnt == CW'(1));

    // Shift-add step: upper half accumulates, lower half holds the multiplier.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Result of an op that completes on the accept edge.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_res    = regInSAR;
        w_carry  = 1'b0;
        w_branch = 1'b0;
        unique case (w_op)
            OP_ADD:  {w_carry, w_res} = w_sum;
            OP_NAND: w_res = ~(regInSAR & regIn);
            OP_BZ:   w_branch = (regInSAR == '0);
            OP_SLT:  w_res = WIDTH'(w_diff[WIDTH]);
            OP_SUB:  {w_carry, w_res} = w_diff;
            default: w_res = regInSAR;
        endcase
    end

    // Result on the last EXEC step, taken from the step being applied.
    always_comb begin
        w_exec_res   = w_acc_next[WIDTH-1:0];
        w_exec_carry = |w_acc_next[2*WIDTH-1:WIDTH];
        if (r_op == OP_SHL) begin
            w_exec_res   = {r_sh[WIDTH-2:0], 1'b0};
            w_exec_carry = r_sh[WIDTH-1];
        end else if (r_op == OP_SHR) begin
            w_exec_res   = {1'b0, r_sh[WIDTH-1:1]};
            w_exec_carry = r_sh[0];
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid) w_next = w_multi ? EXEC : DONE;
            EXEC:    if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= OP_ADD;
            r_a      <= '0;
            r_sh     <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_res    <= '0;
            r_branch <= 1'b0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: if (in_valid) begin
                    r_op  <= w_op;
                    r_a   <= regInSAR;
                    r_sh  <= regInSAR;
                    r_acc <= {{WIDTH{1'b0}}, regIn};
                    r_cnt <= (w_op == OP_MUL) ? CW'(WIDTH) : CW'(w_shamt);
                    if (!w_multi) begin
                        r_res    <= w_res;
                        r_branch <= w_branch;
                        r_zero   <= (w_res == '0);
                        r_carry  <= w_carry;
                    end
                end
                EXEC: begin
                    r_cnt <= r_cnt - CW'(1);
                    r_sh  <= (r_op == OP_SHL) ? {r_sh[WIDTH-2:0], 1'b0} : {1'b0, r_sh[WIDTH-1:1]};
                    r_acc <= w_acc_next;
                    if (w_last) begin
                        r_res    <= w_exec_res;
                        r_branch <= 1'b0;
                        r_zero   <= (w_exec_res == '0);
                        r_carry  <= w_exec_carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign regOut    = r_res;
    assign branch    = r_branch;
    assign zero      = r_zero;
    assign carry     = r_carry;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: each scenario task drives one feature
// and compares outputs against hand-computed values, sampled on the falling edge.
module tb_alu_multicycle;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] control;
    logic [7:0] regInSAR, regIn, regOut;
    logic       branch, zero, carry, out_valid;

    int n_vec = 0;
    int n_err = 0;

    alu_multicycle #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .control(control), .regInSAR(regInSAR), .regIn(regIn), .regOut(regOut),
        .branch(branch), .zero(zero), .carry(carry), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Issue one op from an IDLE cycle; returns the number of falling edges
    // after the accept edge until out_valid is seen (-1 if it never comes).
    task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int lat);
        @(negedge clk);
        control = op; regInSAR = a; regIn = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; regInSAR = ~a; regIn = 8'($urandom);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out_valid) begin lat = i; break; end
        end
    endtask

    task automatic expect_result(input string name, input int lat, input int lat_exp,
                                 input logic [7:0] r_exp, input logic c_exp,
                                 input logic z_exp, input logic b_exp);
        n_vec++;
        if (lat !== lat_exp) begin n_err++; $display("FAIL %s_latency: got %0d want %0d", name, lat, lat_exp); end
        n_vec++;
        if (regOut !== r_exp) begin n_err++; $display("FAIL %s_regOut: got %h want %h", name, regOut, r_exp); end
        n_vec++;
        if ({carry, zero, branch} !== {c_exp, z_exp, b_exp})
            begin n_err++; $display("FAIL %s_flags(c,z,b): got %b want %b", name, {carry, zero, branch}, {c_exp, z_exp, b_exp}); end
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; control = '0; regInSAR = '0; regIn = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_vec++;
        if ({in_ready, out_valid, regOut, carry, zero, branch} !== {1'b1, 1'b0, 8'h00, 3'b000})
            begin n_err++; $display("FAIL reset_state: got rdy=%b ov=%b r=%h czb=%b%b%b want rdy=1 ov=0 r=00 czb=000",
                                    in_ready, out_valid, regOut, carry, zero, branch); end
    endtask

    task automatic test_add;
        int lat;
        do_op(3'b000, 8'hF0, 8'h20, lat);
        expect_result("add", lat, 1, 8'h10, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL add_ready_in_done: got %b want 0", in_ready); end
        @(negedge clk);
        n_vec++;
        if ({out_valid, in_ready} !== 2'b01)
            begin n_err++; $display("FAIL add_after_done: got ov,rdy=%b want 01", {out_valid, in_ready}); end
    endtask

    task automatic test_sub_slt_nand;
        int lat;
        do_op(3'b100, 8'h05, 8'h07, lat);
        expect_result("sub", lat, 1, 8'hFE, 1'b1, 1'b0, 1'b0);
        do_op(3'b011, 8'h05, 8'h07, lat);
        expect_result("slt", lat, 1, 8'h01, 1'b0, 1'b0, 1'b0);
        do_op(3'b011, 8'h07, 8'h05, lat);
        expect_result("slt_false", lat, 1, 8'h00, 1'b0, 1'b1, 1'b0);
        do_op(3'b001, 8'hFF, 8'hFF, lat);
        expect_result("nand", lat, 1, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_bz;
        int lat;
        do_op(3'b010, 8'h00, 8'h5A, lat);
        expect_result("bz_taken", lat, 1, 8'h00, 1'b0, 1'b1, 1'b1);
        do_op(3'b010, 8'h03, 8'h00, lat);
        expect_result("bz_not_taken", lat, 1, 8'h03, 1'b0, 1'b0, 1'b0);
        do_op(3'b010, 8'h00, 8'h00, lat);
        do_op(3'b000, 8'h02, 8'h03, lat);
        expect_result("add_clears_branch", lat, 1, 8'h05, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_shift;
        int lat;
        do_op(3'b101, 8'h81, 8'h03, lat);
        expect_result("shl3", lat, 4, 8'h08, 1'b0, 1'b0, 1'b0);
        do_op(3'b110, 8'h81, 8'h01, lat);
        expect_result("shr1", lat, 2, 8'h40, 1'b1, 1'b0, 1'b0);
        do_op(3'b110, 8'h80, 8'h0F, lat);
        expect_result("shr7", lat, 8, 8'h01, 1'b0, 1'b0, 1'b0);
        do_op(3'b101, 8'h81, 8'h08, lat);
        expect_result("shl0", lat, 1, 8'h81, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_mul_ignore;
        int lat = -1;
        int extra = 0;
        bit held = 1'b1;
        @(negedge clk);
        control = 3'b111; regInSAR = 8'h13; regIn = 8'h0E; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; regInSAR = 8'h00; regIn = 8'h00;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 3) begin in_valid = 1'b1; control = 3'b000; regInSAR = 8'h01; regIn = 8'h01; end
            else in_valid = 1'b0;
            if (out_valid) begin lat = i; break; end
            if (regOut !== 8'h81) held = 1'b0;
        end
        in_valid = 1'b0;
        expect_result("mul", lat, 9, 8'h0A, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (held !== 1'b1) begin n_err++; $display("FAIL mul_regout_held: got %b want 1", held); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        n_vec++;
        if (extra !== 0) begin n_err++; $display("FAIL mul_ignored_request: got %0d extra out_valid want 0", extra); end
    endtask

    task automatic test_reset_abort;
        int lat;
        int seen = 0;
        @(negedge clk);
        control = 3'b111; regInSAR = 8'h13; regIn = 8'h0E; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_vec++;
        if ({in_ready, out_valid, regOut, carry, zero, branch} !== {1'b1, 1'b0, 8'h00, 3'b000})
            begin n_err++; $display("FAIL abort_state: got rdy=%b ov=%b r=%h czb=%b%b%b want rdy=1 ov=0 r=00 czb=000",
                                    in_ready, out_valid, regOut, carry, zero, branch); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_vec++;
        if (seen !== 0) begin n_err++; $display("FAIL abort_no_out_valid: got %0d pulses want 0", seen); end
        do_op(3'b000, 8'h01, 8'h01, lat);
        expect_result("add_after_abort", lat, 1, 8'h02, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [1:0] ov_rdy [1:4];
        @(negedge clk);
        control = 3'b000; regInSAR = 8'h03; regIn = 8'h04; in_valid = 1'b1;
        @(posedge clk);
        #1;
        regInSAR = 8'h10; regIn = 8'h01;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            ov_rdy[i] = {out_valid, in_ready};
            if (i == 1) begin
                n_vec++;
                if (regOut !== 8'h07) begin n_err++; $display("FAIL b2b_first: got %h want 07", regOut); end
            end
            if (i == 3) begin
                in_valid = 1'b0;
                n_vec++;
                if (regOut !== 8'h11) begin n_err++; $display("FAIL b2b_second: got %h want 11", regOut); end
            end
        end
        n_vec++;
        if ({ov_rdy[1], ov_rdy[2], ov_rdy[3], ov_rdy[4]} !== 8'b10_01_10_01)
            begin n_err++; $display("FAIL b2b_handshake: got %b want 10011001",
                                    {ov_rdy[1], ov_rdy[2], ov_rdy[3], ov_rdy[4]}); end
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub_slt_nand;
        test_bz;
        test_shift;
        test_mul_ignore;
        test_reset_abort;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
